pc_flag_unit: RTL and testbench
===============================

Name: pc_flag_unit

Overview:
- Program-sequencing stage directly upstream of the ALU. Holds the program counter that addresses instruction memory, so it selects every instruction the ALU executes.
- Latches the ALU status outputs (carry, negative, zero) into an architectural flag register.
- Resolves BLT/BNE/jump against the latched flags.
- Runs a start/halt control FSM that brackets each program run and counts executed cycles.

Parameters:
- PC_W, 10, program counter width in bits; instruction memory depth is 2^PC_W.
- START_ADDR, 0, PC value loaded on reset and on every start.
- CNT_W, 16, cycle counter width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  begin program run (sampled in IDLE and HALTED).
- halt_i  input  1  decoded HALT for the current instruction.
- jump_i  input  1  decoded unconditional jump.
- br_lt_i  input  1  decoded BLT.
- br_ne_i  input  1  decoded BNE.
- target_i  input  PC_W  absolute branch/jump target.
- flag_we_i  input  1  current instruction writes flags (ALU op).
- carry_i  input  1  ALU carry out.
- neg_i  input  1  ALU negative out.
- zero_i  input  1  ALU zero out; 1 means the result equals 0.
- pc_o  output  PC_W  current PC (registered).
- carry_q_o  output  1  latched carry flag.
- neg_q_o  output  1  latched negative flag.
- zero_q_o  output  1  latched zero flag.
- running_o  output  1  high in RUN.
- done_o  output  1  high in HALTED.
- cycles_o  output  CNT_W  RUN cycles since last start.

Behaviour:
- Reset (async assert, any time including mid-run): state=IDLE, pc_o=START_ADDR, all flags 0, cycles_o=0, running_o=0, done_o=0. Deassertion takes effect at the next rising edge.
- States are IDLE, RUN and HALTED. All outputs are registered; none is combinational from inputs.
- IDLE:
  - start_i=1 -> RUN next edge, with pc=START_ADDR, flags=0, cycles=0.
  - Otherwise hold.
  - All decode/flag inputs are ignored.
- RUN, evaluated each edge with priority halt > jump > conditional > sequential:
  - halt_i=1 -> HALTED. pc holds (points at the HALT instruction). Flags update if flag_we_i. cycles increments for this final cycle.
  - jump_i=1 -> pc=target_i.
  - br_lt_i=1 and neg_q=1 -> pc=target_i.
  - br_ne_i=1 and zero_q=0 -> pc=target_i.
  - br_lt_i and br_ne_i both 1 -> taken if either condition holds.
  - Otherwise pc=pc+1, modulo 2^PC_W (pc=2^PC_W-1 wraps to 0 with no error indication).
- Flags: in RUN only, on flag_we_i=1 load {carry,neg,zero} <= {carry_i,neg_i,zero_i}; otherwise hold.
- Same-cycle flag write and branch: the branch uses the pre-edge (old) flags, and the flags still update at that edge. A flag-setting instruction therefore affects only later branches.
- start_i in RUN is ignored.
- cycles: +1 per RUN cycle, saturates at 2^CNT_W-1, holds in IDLE and HALTED.
- HALTED:
  - done_o=1; pc, flags and cycles hold.
  - start_i=1 -> RUN restart with the same initialisation as from IDLE; done_o drops on that edge.
- Latency: a decision made on instruction N appears on pc_o one cycle later. No delay slot; pc_o is valid in the cycle after entering RUN.

Test Plan:
- Reset then start_i pulse, no decode inputs for 5 cycles -> pc_o = 0,1,2,3,4; running_o=1; cycles_o=5; flags 0.
- Set PC_W=4 and run 17 cycles from START_ADDR=0 -> pc_o goes 15 then wraps to 0, then 1; no stall.
- flag_we_i=1 with neg_i=1 at pc=3, then br_lt_i=1, target_i=0x20 at pc=4 -> pc_o=0x20. Repeat with flag_we_i and br_lt_i in the same cycle while neg_q=0 -> not taken, pc_o=pc+1, neg_q_o=1 afterwards.
- zero_q=1 with br_ne_i=1 -> not taken. zero_q=0 with br_ne_i=1, target 0x3FF -> pc_o=0x3FF. jump_i and halt_i together -> HALTED, pc holds.
- halt_i at pc=7 after 8 RUN cycles -> done_o=1, pc_o=7, cycles_o=8, stable for 10 cycles. Then start_i -> pc_o=0, flags 0, cycles restart at 1.
- rst_ni low asynchronously mid-RUN (between edges) -> outputs return to reset values immediately. After release, the block stays IDLE until start_i.

Source files
------------

// File: rtl/pc_flag_unit.sv
// rtl/pc_flag_unit.sv - program counter, ALU flag register and start/halt run-control FSM
module pc_flag_unit #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             halt_i,
  input  logic             jump_i,
  input  logic             br_lt_i,
  input  logic             br_ne_i,
  input  logic [PC_W-1:0]  target_i,
  input  logic             flag_we_i,
  input  logic             carry_i,
  input  logic             neg_i,
  input  logic             zero_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             carry_q_o,
  output logic             neg_q_o,
  output logic             zero_q_o,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycles_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic             carry, carry_nxt;
  logic             neg, neg_nxt;
  logic             zero, zero_nxt;
  logic [CNT_W-1:0] cycles, cycles_nxt;
  logic             running, done;
  logic             taken;

  // Branches resolve against the flags latched before this edge, never the incoming ALU status.
  assign taken = jump_i | (br_lt_i & neg) | (br_ne_i & ~zero);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    carry_nxt  = carry;
    neg_nxt    = neg;
    zero_nxt   = zero;
    cycles_nxt = cycles;
    case (state)
      IDLE, HALTED: begin
        if (start_i) begin
          state_nxt  = RUN;
          pc_nxt     = START_ADDR;
          carry_nxt  = 1'b0;
          neg_nxt    = 1'b0;
          zero_nxt   = 1'b0;
          cycles_nxt = '0;
        end
      end
      RUN: begin
        if (!(&cycles)) begin
          cycles_nxt = cycles + CNT_W'(1);
        end
        if (flag_we_i) begin
          carry_nxt = carry_i;
          neg_nxt   = neg_i;
          zero_nxt  = zero_i;
        end
        if (halt_i) begin
          state_nxt = HALTED;
        end else if (taken) begin
          pc_nxt = target_i;
        end else begin
          pc_nxt = pc + PC_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      pc      <= START_ADDR;
      carry   <= 1'b0;
      neg     <= 1'b0;
      zero    <= 1'b0;
      cycles  <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      carry   <= carry_nxt;
      neg     <= neg_nxt;
      zero    <= zero_nxt;
      cycles  <= cycles_nxt;
      running <= (state_nxt == RUN);
      done    <= (state_nxt == HALTED);
    end
  end

  assign pc_o      = pc;
  assign carry_q_o = carry;
  assign neg_q_o   = neg;
  assign zero_q_o  = zero;
  assign running_o = running;
  assign done_o    = done;
  assign cycles_o  = cycles;

endmodule

// File: tb/tb_pc_flag_unit.sv
// tb/tb_pc_flag_unit.sv - randomized and directed bench for pc_flag_unit against a behavioural model
module tb_pc_flag_unit;
  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int VW    = PC_W + CNT_W + 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0, halt = 1'b0, jump = 1'b0, br_lt = 1'b0, br_ne = 1'b0;
  logic            flag_we = 1'b0, carry = 1'b0, neg = 1'b0, zero = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic [PC_W-1:0] pc_o;
  logic            carry_q, neg_q, zero_q, running, done;
  logic [CNT_W-1:0] cycles;

  int n_chk = 0;
  int n_fail = 0;

  // Model: mode 0 idle, 1 running, 2 halted.
  int          m_mode;
  int unsigned m_pc, m_cyc;
  bit          m_c, m_n, m_z;

  pc_flag_unit #(.PC_W(PC_W), .START_ADDR(10'd0), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .halt_i(halt), .jump_i(jump),
    .br_lt_i(br_lt), .br_ne_i(br_ne), .target_i(target), .flag_we_i(flag_we),
    .carry_i(carry), .neg_i(neg), .zero_i(zero), .pc_o(pc_o), .carry_q_o(carry_q),
    .neg_q_o(neg_q), .zero_q_o(zero_q), .running_o(running), .done_o(done), .cycles_o(cycles)
  );

  always #5 clk = ~clk;

  logic [VW-1:0] obs;
  assign obs = {pc_o, carry_q, neg_q, zero_q, running, done, cycles};

  function automatic logic [VW-1:0] exp_vec();
    logic [PC_W-1:0]  p;
    logic [CNT_W-1:0] c;
    p = PC_W'(m_pc);
    c = CNT_W'(m_cyc);
    return {p, m_c, m_n, m_z, m_mode == 1, m_mode == 2, c};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cyc = 0; m_c = 0; m_n = 0; m_z = 0;
  endtask

  task automatic step(input bit st, hl, jp, lt, ne, input int unsigned tg, input bit we, c, n, z);
    bit tk;
    start = st; halt = hl; jump = jp; br_lt = lt; br_ne = ne;
    target = PC_W'(tg); flag_we = we; carry = c; neg = n; zero = z;
    @(posedge clk);
    if (m_mode == 1) begin
      tk = jp || (lt && m_n) || (ne && !m_z);
      if (m_cyc < 65535) m_cyc = m_cyc + 1;
      if (hl) m_mode = 2;
      else if (tk) m_pc = tg % 1024;
      else m_pc = (m_pc + 1) % 1024;
      if (we) begin m_c = c; m_n = n; m_z = z; end
    end else if (st) begin
      m_mode = 1; m_pc = 0; m_cyc = 0; m_c = 0; m_n = 0; m_z = 0;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_no_start(input bit allow_halt);
    step(0, allow_halt && ($urandom % 8 == 0), 1'($urandom), 1'($urandom), 1'($urandom),
         $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_chk++;
    if (obs !== exp_vec()) begin
      n_fail++; $display("FAIL reset_values: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_no_start(1);
      n_chk++;
      if (obs !== exp_vec() || running !== 1'b0) begin
        n_fail++; $display("FAIL reset_idle_hold: got %h expected %h", obs, exp_vec());
      end
    end
  endtask

  task automatic test_sequential();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 10'd0 || running !== 1'b1 || cycles !== 16'd0) begin
      n_fail++; $display("FAIL seq_start: got pc=%h run=%b cyc=%0d expected pc=0 run=1 cyc=0", pc_o, running, cycles);
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (pc_o !== PC_W'(i)) begin
        n_fail++; $display("FAIL seq_pc: got %h expected %h", pc_o, i);
      end
      idle();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL seq_model: got %h expected %h", obs, exp_vec());
      end
    end
    n_chk++;
    if (cycles !== 16'd5 || {carry_q, neg_q, zero_q} !== 3'b000 || running !== 1'b1) begin
      n_fail++; $display("FAIL seq_cycles: got cyc=%0d flags=%b run=%b expected cyc=5 flags=000 run=1", cycles, {carry_q, neg_q, zero_q}, running);
    end
  endtask

  task automatic test_wrap();
    int unsigned want[3];
    want[0] = 10'h3FF; want[1] = 0; want[2] = 1;
    step(0, 0, 1, 0, 0, 10'h3FE, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      n_chk++;
      if (pc_o !== PC_W'(want[i]) || obs !== exp_vec()) begin
        n_fail++; $display("FAIL wrap_pc: got %h expected pc %h (model %h)", pc_o, want[i], exp_vec());
      end
    end
  endtask

  task automatic test_branch_flags();
    step(0, 0, 1, 0, 0, 3, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    n_chk++;
    if (pc_o !== 10'd4 || neg_q !== 1'b1) begin
      n_fail++; $display("FAIL blt_setup: got pc=%h neg=%b expected pc=004 neg=1", pc_o, neg_q);
    end
    step(0, 0, 0, 1, 0, 10'h20, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 10'h20) begin
      n_fail++; $display("FAIL blt_taken: got %h expected 020", pc_o);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 10'h40, 1, 0, 1, 0);
    n_chk++;
    if (pc_o !== 10'h22 || neg_q !== 1'b1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL blt_old_flags: got pc=%h neg=%b expected pc=022 neg=1", pc_o, neg_q);
    end
  endtask

  task automatic test_bne_jump_halt();
    int unsigned p;
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    p = m_pc;
    step(0, 0, 0, 0, 1, 10'h100, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== PC_W'((p + 1) % 1024)) begin
      n_fail++; $display("FAIL bne_not_taken: got %h expected %h", pc_o, (p + 1) % 1024);
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 10'h3FF, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 10'h3FF) begin
      n_fail++; $display("FAIL bne_taken: got %h expected 3ff", pc_o);
    end
    step(0, 1, 1, 0, 0, 5, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 10'h3FF || done !== 1'b1 || running !== 1'b0 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL halt_over_jump: got pc=%h done=%b run=%b expected pc=3ff done=1 run=0", pc_o, done, running);
    end
  endtask

  task automatic test_halt_restart();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 10'd0 || cycles !== 16'd0 || running !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL restart_from_halt: got pc=%h cyc=%0d run=%b done=%b", pc_o, cycles, running, done);
    end
    for (int i = 0; i < 7; i++) idle();
    step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      n_chk++;
      if (pc_o !== 10'd7 || cycles !== 16'd8 || done !== 1'b1 || carry_q !== 1'b1 || obs !== exp_vec()) begin
        n_fail++; $display("FAIL halted_stable: got pc=%h cyc=%0d done=%b c=%b expected pc=007 cyc=8 done=1 c=1", pc_o, cycles, done, carry_q);
      end
      rand_no_start(1);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 10'd0 || {carry_q, neg_q, zero_q} !== 3'b000 || cycles !== 16'd0 || done !== 1'b0 || running !== 1'b1) begin
      n_fail++; $display("FAIL restart_init: got pc=%h flags=%b cyc=%0d done=%b", pc_o, {carry_q, neg_q, zero_q}, cycles, done);
    end
    idle();
    n_chk++;
    if (cycles !== 16'd1 || pc_o !== 10'd1) begin
      n_fail++; $display("FAIL restart_count: got cyc=%0d pc=%h expected cyc=1 pc=001", cycles, pc_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom % 12 == 0, $urandom % 24 == 0, $urandom % 6 == 0, 1'($urandom), 1'($urandom),
           $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++; $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    idle();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    n_chk++;
    if (obs !== exp_vec() || running !== 1'b0 || pc_o !== 10'd0) begin
      n_fail++; $display("FAIL async_reset: got %h expected %h", obs, exp_vec());
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_no_start(0);
      n_chk++;
      if (obs !== exp_vec() || running !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle: got %h expected %h", obs, exp_vec());
      end
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (running !== 1'b1 || obs !== exp_vec()) begin
      n_fail++; $display("FAIL post_reset_start: got %h expected %h", obs, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_branch_flags();
    test_bne_jump_halt();
    test_halt_restart();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
